// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types: operand-fetch states, count width helper
// and the register selectors the control FSM routes operands into.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OPF_IDLE    = 3'd0,
        OPF_ADDR    = 3'd1,
        OPF_WAIT    = 3'd2,
        OPF_CAPTURE = 3'd3,
        OPF_DONE    = 3'd4
    } opf_state_e;

    typedef enum logic [2:0] {
        R8_B, R8_C, R8_D, R8_E,
        R8_H, R8_L, R8_A, R8_MHL
    } reg8_e;

    typedef enum logic [1:0] {
        R16_BC, R16_DE, R16_HL, R16_SP
    } reg16_e;

    function automatic int opf_cnt_w(input int max_bytes);
        return (max_bytes < 1) ? 1 : $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/opfetch_wait_ctr.sv
// Loadable wait-state down-counter; expired once the count is at or
// below one, so a load of N yields N wait cycles.
module opfetch_wait_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/operand_fetch_seq.sv
// Immediate-operand fetch sequencer, little-endian assembly.
// OPFETCH_MEM_READY_EN: WAIT additionally holds until mem_ready.
module operand_fetch_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MAX_BYTES   = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
    input  logic [ADDR_W-1:0]             pc_in,
    input  logic [DATA_W-1:0]             mem_data,
    input  logic                          mem_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_cs,
    output logic                          mem_oe,
    output logic                          busy,
    output logic                          done,
    output logic                          pc_wr,
    output logic [ADDR_W-1:0]             pc_out,
    output logic [DATA_W*MAX_BYTES-1:0]   operand
);

    localparam int CW  = opf_cnt_w(MAX_BYTES);
    localparam int WCW = (WAIT_STATES > 0) ?
                         $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] MAXB = CW'(MAX_BYTES);

    opf_state_e                 state_q;
    logic [ADDR_W-1:0]          pc_q;
    logic [ADDR_W-1:0]          pc_inc;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_d;
    logic [CW-1:0]              idx_q;
    logic [DATA_W*MAX_BYTES-1:0] operand_q;
    logic                       mem_cs_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       pc_wr_q;
    logic                       ctr_load;
    logic                       ctr_dec;
    logic                       ctr_expired;
    logic                       wait_exit;

    assign count_d  = (nbytes > MAXB) ? MAXB : nbytes;
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign ctr_load = (state_q == OPF_ADDR);
    assign ctr_dec  = (state_q == OPF_WAIT);

    opfetch_wait_ctr #(
        .W (WCW)
    ) u_wait_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ctr_load),
        .val_i     (WCW'(WAIT_STATES)),
        .dec_i     (ctr_dec),
        .expired_o (ctr_expired)
    );

`ifdef OPFETCH_MEM_READY_EN
    assign wait_exit = ctr_expired && mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign wait_exit        = ctr_expired;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OPF_IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            operand_q  <= '0;
            mem_cs_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_wr_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            pc_wr_q <= 1'b0;
            if (state_q != OPF_IDLE && abort) begin
                state_q  <= OPF_IDLE;
                mem_cs_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    OPF_IDLE: begin
                        if (start) begin
                            pc_q      <= pc_in;
                            count_q   <= count_d;
                            idx_q     <= '0;
                            operand_q <= '0;
                            busy_q    <= 1'b1;
                            if (count_d == '0) begin
                                state_q <= OPF_DONE;
                                done_q  <= 1'b1;
                                pc_wr_q <= 1'b1;
                            end else begin
                                state_q    <= OPF_ADDR;
                                mem_addr_q <= pc_in;
                                mem_cs_q   <= 1'b1;
                            end
                        end
                    end
                    OPF_ADDR: begin
`ifdef OPFETCH_MEM_READY_EN
                        state_q <= OPF_WAIT;
`else
                        state_q <= (WAIT_STATES == 0) ?
                                   OPF_CAPTURE : OPF_WAIT;
`endif
                    end
                    OPF_WAIT: begin
                        if (wait_exit) begin
                            state_q <= OPF_CAPTURE;
                        end
                    end
                    OPF_CAPTURE: begin
                        operand_q[int'(idx_q)*DATA_W +: DATA_W]
                                 <= mem_data;
                        pc_q     <= pc_inc;
                        idx_q    <= idx_q + CW'(1);
                        if (idx_q == count_q - CW'(1)) begin
                            state_q  <= OPF_DONE;
                            mem_cs_q <= 1'b0;
                            done_q   <= 1'b1;
                            pc_wr_q  <= 1'b1;
                        end else begin
                            state_q    <= OPF_ADDR;
                            mem_addr_q <= pc_inc;
                        end
                    end
                    OPF_DONE: begin
                        state_q <= OPF_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q  <= OPF_IDLE;
                        mem_cs_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_cs   = mem_cs_q;
    assign mem_oe   = mem_cs_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pc_wr    = pc_wr_q;
    assign pc_out   = pc_q;
    assign operand  = operand_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Randomized bench for operand_fetch_seq against a byte-level
// memory model; default build (mem_ready ignored).
module tb_operand_fetch_seq;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MB = 2;
    localparam int WS = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1:0]    nbytes;
    logic [AW-1:0] pc_in;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic          mem_oe;
    logic          busy;
    logic          done;
    logic          pc_wr;
    logic [AW-1:0] pc_out;
    logic [15:0]   operand;

    logic [7:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    operand_fetch_seq #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_BYTES   (MB),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .nbytes    (nbytes),
        .pc_in     (pc_in),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .busy      (busy),
        .done      (done),
        .pc_wr     (pc_wr),
        .pc_out    (pc_out),
        .operand   (operand)
    );

    function automatic int ref_count(input logic [1:0] nb);
        return (int'(nb) > MB) ? MB : int'(nb);
    endfunction

    function automatic int ref_cycles(input logic [1:0] nb);
        return 1 + ref_count(nb) * (WS + 2);
    endfunction

    function automatic logic [15:0] ref_op(input logic [1:0] nb,
                                           input logic [15:0] pc);
        logic [15:0] r;
        logic [15:0] a;
        r = '0;
        for (int i = 0; i < ref_count(nb); i++) begin
            a = pc + 16'(i);
            r = r | (16'(mem[a]) << (8 * i));
        end
        return r;
    endfunction

    // Runs one request; returns once in the cycle after done.
    task automatic do_fetch(input  logic [1:0]  nb,
                            input  logic [15:0] pc,
                            input  int          mid,
                            output int          dcyc,
                            output int          ndone,
                            output int          npcwr,
                            output int          ncs,
                            output logic [15:0] op,
                            output logic [15:0] pco);
        dcyc = -1; ndone = 0; npcwr = 0; ncs = 0;
        op = '0; pco = '0;
        nbytes = nb; pc_in = pc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == mid) begin
                start = 1'b1; nbytes = 2'd1; pc_in = 16'h5555;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c; op = operand; pco = pc_out;
                end
            end
            if (pc_wr) npcwr++;
            if (mem_cs) ncs++;
            if (dcyc >= 0 && c > dcyc) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_addr, mem_cs, mem_oe, busy, done, pc_wr,
             pc_out, operand} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h cs=%b busy=%b done=%b pc=%h op=%h want all zero",
                     mem_addr, mem_cs, busy, done, pc_out, operand);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d, nd, np, nc;
        logic [15:0] op, pco;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        do_fetch(2'd2, 16'h0100, 0, d, nd, np, nc, op, pco);
        checks++;
        if (d !== 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 7", d);
        end
        checks++;
        if (op !== 16'h1234) begin
            errors++;
            $display("FAIL basic_operand: got %h want 1234", op);
        end
        checks++;
        if (pco !== 16'h0102) begin
            errors++;
            $display("FAIL basic_pc_out: got %h want 0102", pco);
        end
        checks++;
        if (nd !== 1 || np !== 1) begin
            errors++;
            $display("FAIL basic_pulses: got done=%0d pc_wr=%0d want 1/1",
                     nd, np);
        end
        checks++;
        if (nc !== 2 * (WS + 2)) begin
            errors++;
            $display("FAIL basic_cs_cycles: got %0d want %0d",
                     nc, 2 * (WS + 2));
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after: got busy=%b done=%b want 0/0",
                     busy, done);
        end
    endtask

    task automatic test_wrap();
        int d, nd, np, nc;
        logic [15:0] op, pco;
        mem[16'hFFFF] = 8'hAB;
        do_fetch(2'd1, 16'hFFFF, 0, d, nd, np, nc, op, pco);
        checks++;
        if (d !== 4) begin
            errors++;
            $display("FAIL wrap_latency: got %0d want 4", d);
        end
        checks++;
        if (op !== 16'h00AB || pco !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_result: got op=%h pc=%h want 00ab/0000",
                     op, pco);
        end
    endtask

    task automatic test_zero();
        int d, nd, np, nc;
        logic [15:0] op, pco;
        do_fetch(2'd0, 16'h0200, 0, d, nd, np, nc, op, pco);
        checks++;
        if (d !== 1 || nd !== 1 || np !== 1) begin
            errors++;
            $display("FAIL zero_latency: got cyc=%0d done=%0d pc_wr=%0d want 1/1/1",
                     d, nd, np);
        end
        checks++;
        if (op !== 16'h0000 || pco !== 16'h0200 || nc !== 0) begin
            errors++;
            $display("FAIL zero_result: got op=%h pc=%h cs=%0d want 0000/0200/0",
                     op, pco, nc);
        end
    endtask

    task automatic test_clamp_ignore_start();
        int d, nd, np, nc;
        logic [15:0] op, pco, eop;
        eop = ref_op(2'd3, 16'h0400);
        do_fetch(2'd3, 16'h0400, 3, d, nd, np, nc, op, pco);
        checks++;
        if (d !== ref_cycles(2'd3)) begin
            errors++;
            $display("FAIL clamp_latency: got %0d want %0d",
                     d, ref_cycles(2'd3));
        end
        checks++;
        if (op !== eop || pco !== 16'h0402 || nd !== 1) begin
            errors++;
            $display("FAIL clamp_result: got op=%h pc=%h done=%0d want %h/0402/1",
                     op, pco, nd, eop);
        end
    endtask

    task automatic test_abort();
        int nd;
        nd = 0;
        nbytes = 2'd2; pc_in = 16'h0300; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        checks++;
        if (mem_cs !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got cs=%b busy=%b want 1/1",
                     mem_cs, busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({busy, mem_cs, mem_oe, done, pc_wr} !== 5'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b cs=%b oe=%b done=%b pc_wr=%b want 0",
                     busy, mem_cs, mem_oe, done, pc_wr);
        end
        for (int c = 0; c < 10; c++) begin
            if (done || pc_wr) nd++;
            @(posedge clk); #1;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_rst_mid();
        nbytes = 2'd2; pc_in = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({mem_addr, mem_cs, mem_oe, busy, done, pc_wr,
             pc_out, operand} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got addr=%h cs=%b busy=%b pc=%h op=%h want all zero",
                     mem_addr, mem_cs, busy, pc_out, operand);
        end
    endtask

    task automatic test_back_to_back();
        int d, nd, np, nc;
        logic [15:0] op, pco, eop;
        eop = ref_op(2'd2, 16'h1000);
        do_fetch(2'd2, 16'h1000, 0, d, nd, np, nc, op, pco);
        eop = ref_op(2'd1, 16'h2000);
        do_fetch(2'd1, 16'h2000, 0, d, nd, np, nc, op, pco);
        checks++;
        if (d !== 4 || op !== eop || pco !== 16'h2001) begin
            errors++;
            $display("FAIL b2b_second: got cyc=%0d op=%h pc=%h want 4/%h/2001",
                     d, op, pco, eop);
        end
    endtask

    task automatic test_random();
        int d, nd, np, nc;
        logic [15:0] op, pco, pc, eop;
        logic [1:0] nb;
        for (int i = 0; i < 30; i++) begin
            nb  = 2'($urandom_range(0, 3));
            pc  = 16'($urandom);
            if (i % 7 == 0) pc = 16'hFFFF;
            eop = ref_op(nb, pc);
            do_fetch(nb, pc, 0, d, nd, np, nc, op, pco);
            checks++;
            if (d !== ref_cycles(nb) || op !== eop ||
                pco !== 16'(pc + 16'(ref_count(nb))) ||
                nd !== 1 || np !== 1) begin
                errors++;
                $display("FAIL random_%0d: nb=%0d pc=%h got cyc=%0d op=%h pco=%h done=%0d want cyc=%0d op=%h",
                         i, nb, pc, d, op, pco, nd,
                         ref_cycles(nb), eop);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        nbytes = '0; pc_in = '0; mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_clamp_ignore_start();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
